// File: rtl/dmem_responder_if.sv
// Data-memory port bundle between the MEM stage and the memory responder.
// Master drives the request, slave returns the registered response.
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ack_o, rdata_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ack_o, rdata_o, err_o, busy_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding request,
// registered ack/rdata/err and a busy flag that stalls the pipeline.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          c_we;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic          c_err;
    logic [AW-1:0] c_idx;

    assign accept = bus.req_i &&
                    (state == S_IDLE || state == S_RESP);

    // With no wait states the commit edge is the accept edge, so the
    // committed request comes straight from the bus, not the latches.
    always_comb begin
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (WAIT_CYCLES == 0) begin
            c_we    = bus.we_i;
            c_addr  = bus.addr_i;
            c_wdata = bus.wdata_i;
        end
    end

    assign c_idx = c_addr[AW+1:2];
    assign c_err = (c_addr[1:0] != 2'b00) ||
                   (c_addr[31:AW+2] != '0);

    // Next-state decode for IDLE / WAIT / RESP.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd0)
                    state_nxt = S_RESP;
            end
            S_RESP: begin
                if (accept)
                    state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                else
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign enter_resp = (state_nxt == S_RESP);

    // State register and wait-state counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= CNT_INIT;
            else if (state == S_WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    // Capture the request fields on accept.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wdata_i;
        end
    end

    // Storage array; legal stores commit on the edge entering RESP.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= '0;
        end else if (enter_resp && c_we && !c_err) begin
            mem[c_idx] <= c_wdata;
        end
    end

    // Registered response: ack pulse, error qualifier, read data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.ack_o   <= 1'b0;
            bus.err_o   <= 1'b0;
            bus.rdata_o <= '0;
        end else begin
            bus.ack_o <= enter_resp;
            bus.err_o <= enter_resp && c_err;
            if (enter_resp) begin
                if (c_err)
                    bus.rdata_o <= '0;
                else if (!c_we)
                    bus.rdata_o <= mem[c_idx];
            end
        end
    end

    // Busy is high in every non-IDLE cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            bus.busy_o <= 1'b0;
        else
            bus.busy_o <= (state_nxt != S_IDLE);
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances, WAIT_CYCLES=2
// and WAIT_CYCLES=0, checked with immediate assertions.
module tb_dmem_responder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    dmem_responder_if b2 ();
    dmem_responder_if b0 ();

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) dut2 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (b2)
    );

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on the WAIT_CYCLES=2 instance; lat counts edges
    // from the accept edge (inclusive) to the one after which ack is seen.
    task automatic txn2(input logic we, input logic [31:0] a,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rd, output logic e);
        b2.req_i   = 1'b1;
        b2.we_i    = we;
        b2.addr_i  = a;
        b2.wdata_i = d;
        @(posedge clk); #1;
        b2.req_i = 1'b0;
        lat = 1;
        while (b2.ack_o !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = b2.rdata_o;
        e  = b2.err_o;
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        logic        busy_ok;
        int          first;
        int          second;
        logic [31:0] dat;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        b2.req_i = 1'b0; b2.we_i = 1'b0;
        b2.addr_i = '0;  b2.wdata_i = '0;
        b0.req_i = 1'b0; b0.we_i = 1'b0;
        b0.addr_i = '0;  b0.wdata_i = '0;

        // Reset, then idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_ack",   32'(b2.ack_o),  32'd0);
            chk("idle_busy",  32'(b2.busy_o), 32'd0);
            chk("idle_rdata", b2.rdata_o,     32'd0);
        end
        chk("idle0_busy",  32'(b0.busy_o), 32'd0);
        chk("idle0_rdata", b0.rdata_o,     32'd0);

        // Store then load
        txn2(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e);
        chk("st_lat", 32'(lat), 32'd3);
        chk("st_err", 32'(e),   32'd0);
        chk("st_idle_busy", 32'(b2.busy_o), 32'd0);
        txn2(1'b0, 32'h10, 32'h0, lat, rd, e);
        chk("ld_lat",   32'(lat), 32'd3);
        chk("ld_rdata", rd,       32'hDEADBEEF);
        chk("ld_err",   32'(e),   32'd0);

        // Back-to-back store then load of 0x4
        b2.req_i   = 1'b1;
        b2.we_i    = 1'b1;
        b2.addr_i  = 32'h4;
        b2.wdata_i = 32'h11;
        @(posedge clk); #1;
        b2.we_i    = 1'b0;
        b2.wdata_i = 32'h0;
        busy_ok = 1'b1;
        first   = 0;
        second  = 0;
        rd      = '0;
        e       = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k <= 6 && b2.busy_o !== 1'b1)
                busy_ok = 1'b0;
            if (b2.ack_o === 1'b1) begin
                if (first == 0) begin
                    first = k;
                end else if (second == 0) begin
                    second = k;
                    rd = b2.rdata_o;
                    e  = b2.err_o;
                end
            end
            if (k == 4)
                b2.req_i = 1'b0;
        end
        chk("b2b_first",  32'(first),          32'd3);
        chk("b2b_gap",    32'(second - first), 32'd3);
        chk("b2b_busy",   32'(busy_ok),        32'd1);
        chk("b2b_rdata",  rd,                  32'h11);
        chk("b2b_err",    32'(e),              32'd0);
        chk("b2b_idle",   32'(b2.busy_o),      32'd0);

        // Errors
        txn2(1'b0, 32'h6, 32'h0, lat, rd, e);
        chk("mis_lat",   32'(lat), 32'd3);
        chk("mis_err",   32'(e),   32'd1);
        chk("mis_rdata", rd,       32'd0);
        txn2(1'b1, 32'h200, 32'hCAFEF00D, lat, rd, e);
        chk("oor_err", 32'(e), 32'd1);
        txn2(1'b0, 32'h0, 32'h0, lat, rd, e);
        chk("wrap_rdata", rd,     32'd0);
        chk("wrap_err",   32'(e), 32'd0);
        txn2(1'b0, 32'h4, 32'h0, lat, rd, e);
        chk("ld4_rdata", rd, 32'h11);

        // Reset mid-operation
        b2.req_i   = 1'b1;
        b2.we_i    = 1'b1;
        b2.addr_i  = 32'h8;
        b2.wdata_i = 32'h55;
        @(posedge clk); #1;
        b2.req_i = 1'b0;
        chk("mid_busy_pre", 32'(b2.busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy_rst", 32'(b2.busy_o), 32'd0);
        chk("mid_rdata_rst", b2.rdata_o, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("mid_ack_rst", 32'(b2.ack_o), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_ack_post", 32'(b2.ack_o),  32'd0);
            chk("mid_busy_post", 32'(b2.busy_o), 32'd0);
        end
        txn2(1'b0, 32'h8, 32'h0, lat, rd, e);
        chk("mid_ld8", rd, 32'd0);
        txn2(1'b0, 32'h10, 32'h0, lat, rd, e);
        chk("mid_ld10", rd, 32'd0);

        // Zero wait states: alternating store/load every cycle
        for (int i = 0; i < 16; i++) begin
            dat = 32'hA5000000 | 32'(i / 2);
            b0.req_i   = 1'b1;
            b0.we_i    = (i % 2 == 0);
            b0.addr_i  = 32'h20 + 32'((i / 2) * 4);
            b0.wdata_i = dat;
            @(posedge clk); #1;
            chk("z_ack",  32'(b0.ack_o),  32'd1);
            chk("z_busy", 32'(b0.busy_o), 32'd1);
            chk("z_err",  32'(b0.err_o),  32'd0);
            if (i % 2 == 1)
                chk("z_rdata", b0.rdata_o, dat);
        end
        b0.req_i = 1'b0;
        @(posedge clk); #1;
        chk("z_end_ack",  32'(b0.ack_o),  32'd0);
        chk("z_end_busy", 32'(b0.busy_o), 32'd0);
        chk("z_hold",     b0.rdata_o,     32'hA5000007);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipelined CPU's data-memory port. It accepts one load or store request at a time from the MEM stage and services it after a fixed, parameterised number of wait states. It returns a one-cycle acknowledge with read data or an error flag. While a request is outstanding it raises `busy_o`, which the hazard unit uses to freeze PC and the pipeline registers.

## Interface
- `DEPTH_WORDS`, default 128: number of 32-bit words stored. Must be a power of two, at least 4.
- `WAIT_CYCLES`, default 2: wait states between accept and response. Legal range 0..15.

Ports:
- `clk_i`, input, 1: single clock. All state updates on the rising edge.
- `rst_i`, input, 1: reset, asynchronous and active-low.
- `req_i`, input, 1: request valid. Sampled only in IDLE or RESP.
- `we_i`, input, 1: 1 = store, 0 = load. Captured with the request.
- `addr_i`, input, 32: byte address. Captured with the request.
- `wdata_i`, input, 32: store data. Captured with the request.
- `ack_o`, output, 1: response valid. High for exactly one cycle per accepted request.
- `rdata_o`, output, 32: load data. Valid while `ack_o` is high, then held until the next response.
- `err_o`, output, 1: error qualifier. Valid only while `ack_o` is high.
- `busy_o`, output, 1: high whenever the state is not IDLE.

## Operation
- State machine states: IDLE, WAIT, RESP. The encoding is free.
- **Accept condition:** `req_i`=1 on a rising edge while the state is IDLE or RESP. On accept, latch `we_i`, `addr_i` and `wdata_i` into request registers.
- **Transitions on accept:**
  - If `WAIT_CYCLES`>0: go to WAIT and load the wait counter with `WAIT_CYCLES`-1.
  - If `WAIT_CYCLES`=0: go directly to RESP.
- **WAIT:** each edge decrements the counter. On the edge where the counter is 0, go to RESP.
  - `req_i` and all other inputs are ignored in WAIT.
- **RESP:** lasts one cycle, with `ack_o`=1.
  - Next state is IDLE if `req_i`=0.
  - If `req_i`=1, the request is accepted and the transition follows the accept rules above. This is the back-to-back path.
- **Commit:** happens on the edge that enters RESP, using the latched request.
  - A legal store writes the word to `mem[idx]`.
  - A legal load registers `mem[idx]` into `rdata_o`.
  - `idx` = latched `addr[log2(DEPTH_WORDS)+1:2]`.
- **Error:** a request is in error if latched `addr[1:0]`≠0 or latched `addr` ≥ 4×`DEPTH_WORDS`.
  - On error: `err_o`=1, no memory write occurs, and `rdata_o` is set to 0 (for both loads and stores).
- **Non-error outputs:**
  - After a store, `rdata_o` is unchanged.
  - `err_o`=0 on every non-error response.
- **Reset** (`rst_i`=0, async):
  - State goes to IDLE and the counter is cleared.
  - `ack_o`=0, `err_o`=0, `busy_o`=0, `rdata_o`=0.
  - All memory words are cleared to 0.
  - An in-flight request that has not yet reached its commit edge is discarded: no write, no ack.
- The first edge after reset deasserts may accept a request.

## Timing
- Let the accept edge be E0.
- `ack_o` is high in the cycle following edge E0+`WAIT_CYCLES`.
  - Accept-to-ack latency is `WAIT_CYCLES`+1 edges.
  - For `WAIT_CYCLES`=0, ack appears in the cycle right after E0.
- `busy_o`:
  - Rises in the cycle after E0.
  - Stays high through the RESP cycle.
  - Falls only if no back-to-back accept occurs; otherwise it stays high continuously.
- Back-to-back throughput is one request per `WAIT_CYCLES`+1 cycles.
- `ack_o`, `err_o`, `rdata_o` and `busy_o` are all registered, with no combinational path from any input.
- **Store then load to the same address:** the load observes the new data, because the store commits before the load's accept edge.

## Test plan
- **Reset, then idle:** hold `rst_i`=0, then release with `req_i`=0. Required: `ack_o`=0, `busy_o`=0 and `rdata_o`=0 for 10 cycles.
- **Store then load** (`WAIT_CYCLES`=2):
  - Store 0xDEADBEEF to address 0x10; ack follows 3 edges after accept with `err_o`=0.
  - Then load 0x10; `rdata_o`=0xDEADBEEF with ack 3 edges after accept.
- **Back-to-back:**
  - Hold `req_i`=1 for store 0x4←0x11, then in the RESP cycle present load 0x4.
  - Required: `busy_o` stays continuously high, the second ack arrives 3 edges after the first, and `rdata_o`=0x11.
- **Errors:**
  - Load 0x6 (misaligned): ack with `err_o`=1 and `rdata_o`=0.
  - Store 0x200 with `DEPTH_WORDS`=128: `err_o`=1, and a subsequent load of 0x0 returns 0 (no wrap-around write).
- **Reset mid-operation:**
  - Store 0x8←0x55, then assert `rst_i` low during WAIT.
  - Required: no ack, and after release a load of 0x8 returns 0.
- **Zero wait states** (`WAIT_CYCLES`=0): alternate store and load every cycle across 8 addresses. Required: an ack every cycle, with correct read-back.
